hedios_cmd_dispatch: RTL

- Consumer stage directly downstream of the serial RX packet queue.
- Pops one {command[7:0], data[31:0]} packet at a time and decodes the command.
- Executes the command against an internal bank of 32-bit control registers.
- Emits response packets on a valid/ready interface that feeds the serial TX path.

---
 rtl/hedios_cmd_dispatch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hedios_cmd_dispatch.sv
// hedios_cmd_dispatch: pops {command, data} packets from the RX queue,
// executes NOP/WRITE/READ/PING against a bank of 32-bit control registers,
// and returns response packets on a valid/ready interface toward TX.
// Optional build macro HEDIOS_DISPATCH_WRITE_ACK_EN: when defined, a
// successful WRITE is acknowledged with a response echoing command and data.
module hedios_cmd_dispatch #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   queue_empty,
  input  logic [7:0]             packet_command,
  input  logic [31:0]            packet_data,
  output logic                   pop_packet,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [7:0]             resp_command,
  output logic [31:0]            resp_data,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    reg_wr_pulse,
  output logic                   err_pulse,
  output logic [7:0]             err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_PING  = 2'd3;

  logic [1:0]  state;
  logic [7:0]  cmd_q;
  logic [31:0] data_q;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] rd_data;

  logic [1:0] op;
  logic [5:0] addr;
  logic       addr_ok;
  logic       wr_en;

  assign op      = cmd_q[7:6];
  assign addr    = cmd_q[5:0];
  assign addr_ok = ({1'b0, addr} < 7'(NUM_REGS));
  assign wr_en   = (state == ST_EXEC) && (op == OP_WRITE) && addr_ok;

  // Pop is gated by reset so the queue is never drained while held in reset.
  assign pop_packet = (state == ST_IDLE) && !queue_empty && !rst;
  assign resp_valid = (state == ST_RESP);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[32*g +: 32] = regs[g];
  end

  // Read mux: selects the addressed register for READ responses.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 6'(i)) rd_data = regs[i];
    end
  end

  // Register bank writes plus the per-register strobe that lands with the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_en) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr == 6'(i)) begin
            regs[i]         <= data_q;
            reg_wr_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Control FSM: capture on pop, execute for one cycle, then hold any response until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      data_q       <= '0;
      resp_command <= '0;
      resp_data    <= '0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!queue_empty) begin
            cmd_q  <= packet_command;
            data_q <= packet_data;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          case (op)
            OP_WRITE: begin
              if (addr_ok) begin
`ifdef HEDIOS_DISPATCH_WRITE_ACK_EN
                resp_command <= cmd_q;
                resp_data    <= data_q;
                state        <= ST_RESP;
`else
                state        <= ST_IDLE;
`endif
              end else begin
                err_pulse <= 1'b1;
                err_count <= (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
              end
            end
            OP_READ: begin
              state <= ST_RESP;
              if (addr_ok) begin
                resp_command <= cmd_q;
                resp_data    <= rd_data;
              end else begin
                resp_command <= 8'hFF;
                resp_data    <= {24'h0, cmd_q};
                err_pulse    <= 1'b1;
                err_count    <= (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
              end
            end
            OP_PING: begin
              resp_command <= cmd_q;
              resp_data    <= data_q;
              state        <= ST_RESP;
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
